// File: rtl/tile_map_render_if.sv
// tile_map_render_if: VGA timing counters, strobes and pixel colour passed between draw stages
// master drives the bundle, slave receives it
interface tile_map_render_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;
  modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/tile_map_render.sv
// tile_map_render: overlays a tile map on the pixel stream and reports hero wall contact per frame
// clk/rst: pixel clock, asynchronous active-low reset
// tim_in/tim_out: timing + rgb bundle, output delayed 2 cycles with rendered rgb
// map: packed tile codes, tile (c,r) at [(r*MAP_W+c)*CODE_W +: CODE_W]
// hero_x_pos/hero_y_pos: hero top-left, latched at vblank start
// collision {up,down,left,right}, wall_x_pos/wall_y_pos: results of the previous frame
module tile_map_render #(
  parameter int          MAP_W    = 15,
  parameter int          MAP_H    = 10,
  parameter int          TILE     = 60,
  parameter int          CODE_W   = 2,
  parameter int          ORIGIN_X = 61,
  parameter int          ORIGIN_Y = 108,
  parameter int          HERO_SZ  = 60,
  parameter logic [11:0] COLOR1   = 12'hf00,
  parameter logic [11:0] COLOR2   = 12'h630,
  parameter logic [11:0] COLOR3   = 12'h888
) (
  input  logic                           clk,
  input  logic                           rst,
  tile_map_render_if.slave               tim_in,
  tile_map_render_if.master              tim_out,
  input  logic [MAP_W*MAP_H*CODE_W-1:0]  map,
  input  logic [11:0]                    hero_x_pos,
  input  logic [11:0]                    hero_y_pos,
  output logic [3:0]                     collision,
  output logic [11:0]                    wall_x_pos,
  output logic [11:0]                    wall_y_pos
);
  localparam int PW = TILE > 1 ? $clog2(TILE) : 1;
  localparam int CW = MAP_W > 1 ? $clog2(MAP_W) : 1;
  localparam int RW = MAP_H > 1 ? $clog2(MAP_H) : 1;
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } tim_t;
  tim_t tin, t1_d, t1_q, t2_d, t2_q;
  logic [CODE_W-1:0] tiles [MAP_H][MAP_W];
  logic [PW-1:0] px_d, px_q, py_d, py_q;
  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic in_x_d, in_x_q, in_y_d, in_y_q, in_map_d, in_map_q;
  logic [CODE_W-1:0] code_d, code_q;
  logic [11:0] hx_d, hx_q, hy_d, hy_q;
  logic [11:0] cap_x_d, cap_x_q, cap_y_d, cap_y_q;
  logic [11:0] wall_x_d, wall_x_q, wall_y_d, wall_y_q;
  logic [3:0] acc_d, acc_q, coll_d, coll_q, hit;
  logic seen_d, seen_q;
  logic line_start, frame_start, frame_end, px_last, col_last, py_last, row_last;
  logic [11:0] x, y, hx_end, hy_end;
  logic x_in, y_in, solid, first;
  for (genvar r = 0; r < MAP_H; r++) begin : g_r
    for (genvar c = 0; c < MAP_W; c++) begin : g_c
      assign tiles[r][c] = map[(r*MAP_W+c)*CODE_W +: CODE_W];
    end
  end
  assign tin = {tim_in.hcount, tim_in.vcount, tim_in.hsync, tim_in.hblnk,
                tim_in.vsync, tim_in.vblnk, tim_in.rgb};
  assign tim_out.hcount = t2_q.hc;
  assign tim_out.vcount = t2_q.vc;
  assign tim_out.hsync  = t2_q.hs;
  assign tim_out.hblnk  = t2_q.hb;
  assign tim_out.vsync  = t2_q.vs;
  assign tim_out.vblnk  = t2_q.vb;
  assign tim_out.rgb    = t2_q.rgb;
  assign collision  = coll_q;
  assign wall_x_pos = wall_x_q;
  assign wall_y_pos = wall_y_q;
  // stage 1: running tile counters; the _q values describe the pixel held in t1_q
  always_comb begin
    line_start  = tin.hc == 11'd0;
    frame_start = line_start && tin.vc == 11'd0;
    px_last  = px_q == PW'(TILE - 1);
    col_last = col_q == CW'(MAP_W - 1);
    py_last  = py_q == PW'(TILE - 1);
    row_last = row_q == RW'(MAP_H - 1);
    px_d   = px_q;
    col_d  = col_q;
    in_x_d = in_x_q;
    py_d   = py_q;
    row_d  = row_q;
    in_y_d = in_y_q;
    if (tin.hc == 11'(ORIGIN_X)) begin
      px_d   = '0;
      col_d  = '0;
      in_x_d = 1'b1;
    end else if (in_x_q) begin
      px_d   = px_last ? '0 : px_q + 1'b1;
      col_d  = !px_last ? col_q : col_last ? '0 : col_q + 1'b1;
      in_x_d = !(px_last && col_last);
    end
    if (line_start && tin.vc == 11'(ORIGIN_Y)) begin
      py_d   = '0;
      row_d  = '0;
      in_y_d = 1'b1;
    end else if (line_start && in_y_q) begin
      py_d   = py_last ? '0 : py_q + 1'b1;
      row_d  = !py_last ? row_q : row_last ? '0 : row_q + 1'b1;
      in_y_d = !(py_last && row_last);
    end
    if (frame_start) begin
      px_d   = '0;
      col_d  = '0;
      in_x_d = 1'b0;
      py_d   = '0;
      row_d  = '0;
      in_y_d = 1'b0;
    end
    t1_d     = tin;
    code_d   = tiles[row_d][col_d];
    in_map_d = in_x_d && in_y_d;
  end
  // stage 2: colour, contact test against the latched hero box, frame commit
  always_comb begin
    frame_end = tin.vb && !t1_q.vb;
    x      = {1'b0, t1_q.hc};
    y      = {1'b0, t1_q.vc};
    hx_end = hx_q + 12'(HERO_SZ);
    hy_end = hy_q + 12'(HERO_SZ);
    x_in   = x >= hx_q && x < hx_end;
    y_in   = y >= hy_q && y < hy_end;
    solid  = in_map_q && code_q != '0;
    // hx-1/hy-1 wrap to 12'hfff at 0, which no pixel reaches
    hit = solid ? {y == hy_q - 12'd1 && x_in, y == hy_end && x_in,
                   x == hx_q - 12'd1 && y_in, x == hx_end && y_in} : 4'b0000;
    first = |hit && !seen_q;
    t2_d     = t1_q;
    t2_d.rgb = (t1_q.hb || t1_q.vb) ? 12'h000 : !solid ? t1_q.rgb :
               code_q == CODE_W'(1) ? COLOR1 : code_q == CODE_W'(2) ? COLOR2 : COLOR3;
    hx_d     = frame_end ? hero_x_pos : hx_q;
    hy_d     = frame_end ? hero_y_pos : hy_q;
    acc_d    = frame_end ? 4'b0000 : acc_q | hit;
    seen_d   = frame_end ? 1'b0 : seen_q || first;
    cap_x_d  = first ? 12'(col_q) * 12'(TILE) + 12'(ORIGIN_X) : cap_x_q;
    cap_y_d  = first ? 12'(row_q) * 12'(TILE) + 12'(ORIGIN_Y) : cap_y_q;
    coll_d   = frame_end ? acc_q : coll_q;
    wall_x_d = frame_end ? (seen_q ? cap_x_q : 12'd0) : wall_x_q;
    wall_y_d = frame_end ? (seen_q ? cap_y_q : 12'd0) : wall_y_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      t1_q     <= '0;
      t2_q     <= '0;
      px_q     <= '0;
      col_q    <= '0;
      in_x_q   <= 1'b0;
      py_q     <= '0;
      row_q    <= '0;
      in_y_q   <= 1'b0;
      code_q   <= '0;
      in_map_q <= 1'b0;
      hx_q     <= '0;
      hy_q     <= '0;
      acc_q    <= '0;
      seen_q   <= 1'b0;
      cap_x_q  <= '0;
      cap_y_q  <= '0;
      coll_q   <= '0;
      wall_x_q <= '0;
      wall_y_q <= '0;
    end else begin
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      px_q     <= px_d;
      col_q    <= col_d;
      in_x_q   <= in_x_d;
      py_q     <= py_d;
      row_q    <= row_d;
      in_y_q   <= in_y_d;
      code_q   <= code_d;
      in_map_q <= in_map_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      acc_q    <= acc_d;
      seen_q   <= seen_d;
      cap_x_q  <= cap_x_d;
      cap_y_q  <= cap_y_d;
      coll_q   <= coll_d;
      wall_x_q <= wall_x_d;
      wall_y_q <= wall_y_d;
    end
endmodule

// File: tb/tb_tile_map_render.sv
// tb_tile_map_render: directed frames with a sparse raster (full lines only where probed)
module tb_tile_map_render;
  localparam int HT = 1000;
  localparam int VB = 712;
  localparam int VT = 720;
  typedef struct {
    int f;
    int h;
    int v;
    logic [11:0] rgb;
  } probe_t;
  typedef struct {
    int c0; int r0; int k0;
    int c1; int r1; int k1;
    logic [11:0] hx;
    logic [11:0] hy;
    logic [3:0]  coll;
    logic [11:0] wx;
    logic [11:0] wy;
  } frame_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [299:0] map_v = '0;
  logic [11:0] hero_x = '0;
  logic [11:0] hero_y = '0;
  logic [3:0] collision;
  logic [11:0] wall_x, wall_y;
  probe_t probes[$];
  frame_t frames[$];
  bit seen [0:63];
  int checks = 0;
  int failures = 0;
  int frame = -1;
  int since_rst = 0;
  logic [25:0] prev_tim = '0;
  logic [27:0] prev_exp = '0;
  logic [27:0] exp_res;
  tile_map_render_if tin_if();
  tile_map_render_if tout_if();
  always #5 clk = ~clk;
  tile_map_render dut (
    .clk(clk),
    .rst(rst),
    .tim_in(tin_if),
    .tim_out(tout_if),
    .map(map_v),
    .hero_x_pos(hero_x),
    .hero_y_pos(hero_y),
    .collision(collision),
    .wall_x_pos(wall_x),
    .wall_y_pos(wall_y)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_tile(input int c, input int r, input int k);
    map_v = map_v | (300'(k[1:0]) << ((r * 15 + c) * 2));
  endtask
  task automatic drive(input int h, input int v);
    logic [25:0] cur;
    tin_if.hcount = 11'(h);
    tin_if.vcount = 11'(v);
    tin_if.hsync  = h >= 985 && h < 995;
    tin_if.hblnk  = h >= 980;
    tin_if.vsync  = v >= 714 && v < 717;
    tin_if.vblnk  = v >= VB;
    tin_if.rgb    = 12'h0f0;
    cur = {tin_if.hcount, tin_if.vcount, tin_if.hsync, tin_if.hblnk, tin_if.vsync, tin_if.vblnk};
    @(posedge clk);
    #1;
    since_rst = rst ? since_rst + 1 : 0;
    if (since_rst >= 2)
      check("timing", 64'({tout_if.hcount, tout_if.vcount, tout_if.hsync, tout_if.hblnk,
                           tout_if.vsync, tout_if.vblnk}), 64'(prev_tim));
    prev_tim = cur;
    for (int i = 0; i < probes.size(); i++)
      if (probes[i].f == frame && int'(tout_if.hcount) == probes[i].h && int'(tout_if.vcount) == probes[i].v) begin
        check($sformatf("rgb f%0d (%0d,%0d)", frame, probes[i].h, probes[i].v),
              64'(tout_if.rgb), 64'(probes[i].rgb));
        seen[i] = 1'b1;
      end
  endtask
  task automatic run_lines(input int v0, input int v1);
    for (int v = v0; v < v1; v++) begin
      int hn;
      hn = (v == 108 || v == 167 || v == 168 || v == 228 || v == 648 || v == 707 || v == 708) ? HT : 1;
      for (int h = 0; h < hn; h++) drive(h, v);
    end
  endtask
  initial begin
    probes.push_back('{0, 61, 108, 12'h0f0});
    probes.push_back('{0, 500, 167, 12'h0f0});
    probes.push_back('{0, 985, 108, 12'h000});
    probes.push_back('{0, 0, 712, 12'h000});
    probes.push_back('{1, 181, 108, 12'hf00});
    probes.push_back('{1, 240, 167, 12'hf00});
    probes.push_back('{1, 180, 167, 12'h0f0});
    probes.push_back('{1, 241, 108, 12'h0f0});
    probes.push_back('{2, 121, 108, 12'hf00});
    probes.push_back('{2, 150, 228, 12'hf00});
    probes.push_back('{2, 181, 228, 12'h0f0});
    probes.push_back('{3, 61, 108, 12'hf00});
    probes.push_back('{3, 120, 167, 12'hf00});
    probes.push_back('{3, 121, 108, 12'h0f0});
    probes.push_back('{3, 61, 168, 12'h0f0});
    probes.push_back('{3, 901, 648, 12'h630});
    probes.push_back('{3, 960, 707, 12'h630});
    probes.push_back('{3, 961, 648, 12'h0f0});
    probes.push_back('{3, 900, 648, 12'h0f0});
    probes.push_back('{3, 960, 708, 12'h0f0});
    probes.push_back('{3, 985, 648, 12'h000});
    // hero is changed at line 130 of each frame and judged in the frame after
    frames.push_back('{0, 0, 0, 0, 0, 0, 12'd121, 12'd108, 4'b0000, 12'd0, 12'd0});
    frames.push_back('{2, 0, 1, 0, 0, 0, 12'd121, 12'd168, 4'b0001, 12'd181, 12'd108});
    frames.push_back('{1, 0, 1, 1, 2, 1, 12'd0, 12'd0, 4'b1100, 12'd121, 12'd108});
    frames.push_back('{0, 0, 1, 14, 9, 2, 12'd0, 12'd0, 4'b0000, 12'd0, 12'd0});
    for (int i = 0; i < 6; i++) begin
      drive(200 + i, 300);
      check("reset_timing_rgb", 64'({tout_if.hcount, tout_if.vcount, tout_if.hsync, tout_if.hblnk,
                                     tout_if.vsync, tout_if.vblnk, tout_if.rgb}), 64'd0);
      check("reset_contact", 64'({collision, wall_x, wall_y}), 64'd0);
    end
    rst = 1'b1;
    drive(10, 300);
    drive(11, 300);
    check("latency_hcount", 64'(tout_if.hcount), 64'd10);
    check("latency_rgb", 64'(tout_if.rgb), 64'h0f0);
    for (int f = 0; f < frames.size(); f++) begin
      frame = f;
      map_v = '0;
      set_tile(frames[f].c0, frames[f].r0, frames[f].k0);
      set_tile(frames[f].c1, frames[f].r1, frames[f].k1);
      run_lines(0, 130);
      hero_x = frames[f].hx;
      hero_y = frames[f].hy;
      run_lines(130, VB);
      check($sformatf("hold f%0d", f), 64'({collision, wall_x, wall_y}), 64'(prev_exp));
      run_lines(VB, VT);
      exp_res = {frames[f].coll, frames[f].wx, frames[f].wy};
      check($sformatf("commit f%0d", f), 64'({collision, wall_x, wall_y}), 64'(exp_res));
      prev_exp = exp_res;
    end
    for (int i = 0; i < probes.size(); i++)
      check($sformatf("probe_reached %0d", i), 64'(seen[i]), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
